// File: rtl/bist_pkg.sv
// Shared definitions for the BIST scan sequencer: state encoding,
// default MISR polynomial and default chain/pattern geometry.
package bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_SHIFT,
      ST_CAPTURE,
      ST_UNLOAD,
      ST_COMPARE,
      ST_DONE
   } state_t;

   localparam logic [15:0] MISR_POLY16      = 16'h1021;
   localparam int          DEF_CHAIN_LEN    = 8;
   localparam int          DEF_NUM_PATTERNS = 16;

endpackage

// File: rtl/bist_scan_controller_misr.sv
// Multiple-input signature register compacting the scan_out stream,
// serial input folded into bit 0.
module misr
   import bist_pkg::*;
#(
   parameter int                   SIG_WIDTH = 16,
   parameter logic [SIG_WIDTH-1:0] POLY      = SIG_WIDTH'(MISR_POLY16)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 enable,
   input  logic                 scan_out,
   output logic [SIG_WIDTH-1:0] signature
);

   logic [SIG_WIDTH-1:0] r_sig;
   logic [SIG_WIDTH-1:0] w_next;

   always_comb begin
      w_next = (r_sig << 1)
             ^ (r_sig[SIG_WIDTH-1] ? POLY : '0)
             ^ SIG_WIDTH'(scan_out);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_sig <= '0;
      end else if (clear) begin
         r_sig <= '0;
      end else if (enable) begin
         r_sig <= w_next;
      end
   end

   assign signature = r_sig;

endmodule

// File: rtl/bist_scan_controller.sv
// BIST sequencer: drives LFSR and scan enable, compacts the chain
// response into a MISR and checks it against a golden signature.
module bist_scan_controller
   import bist_pkg::*;
#(
   parameter int                   CHAIN_LEN    = DEF_CHAIN_LEN,
   parameter int                   NUM_PATTERNS = DEF_NUM_PATTERNS,
   parameter int                   SIG_WIDTH    = 16,
   parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG   = '0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 scan_out,
   output logic                 lfsr_mode,
   output logic                 lfsr_reset,
   output logic                 scan_enable,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [SIG_WIDTH-1:0] signature
);

   localparam int SCW = $clog2(CHAIN_LEN + 1);
   localparam int PCW = $clog2(NUM_PATTERNS + 1);

   localparam logic [SCW-1:0] SC_LAST = SCW'(CHAIN_LEN - 1);
   localparam logic [PCW-1:0] PC_END  = PCW'(NUM_PATTERNS);
   localparam logic [SIG_WIDTH-1:0] POLY = SIG_WIDTH'(MISR_POLY16);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [SCW-1:0]       r_shift_cnt;
   logic [SCW-1:0]       w_shift_cnt_nxt;
   logic [PCW-1:0]       r_pat_cnt;
   logic [PCW-1:0]       w_pat_cnt_nxt;
   logic                 r_pass;
   logic                 w_pass_nxt;
   logic                 w_misr_clr;
   logic                 w_misr_en;
   logic [SIG_WIDTH-1:0] w_sig;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_shift_cnt <= '0;
         r_pat_cnt   <= '0;
         r_pass      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_shift_cnt <= w_shift_cnt_nxt;
         r_pat_cnt   <= w_pat_cnt_nxt;
         r_pass      <= w_pass_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_shift_cnt_nxt = r_shift_cnt;
      w_pat_cnt_nxt   = r_pat_cnt;
      w_pass_nxt      = r_pass;
      w_misr_clr      = 1'b0;
      w_misr_en       = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (start) w_state_nxt = ST_INIT;
         end
         ST_INIT: begin
            w_misr_clr      = 1'b1;
            w_pat_cnt_nxt   = '0;
            w_shift_cnt_nxt = '0;
            w_state_nxt     = ST_SHIFT;
         end
         ST_SHIFT: begin
            // pattern 0 only flushes reset contents, not a response
            w_misr_en = (r_pat_cnt != '0);
            if (r_shift_cnt == SC_LAST) begin
               w_shift_cnt_nxt = '0;
               w_state_nxt     = ST_CAPTURE;
            end else begin
               w_shift_cnt_nxt = r_shift_cnt + SCW'(1);
            end
         end
         ST_CAPTURE: begin
            w_pat_cnt_nxt = r_pat_cnt + PCW'(1);
            w_state_nxt   = (w_pat_cnt_nxt == PC_END) ? ST_UNLOAD
                                                      : ST_SHIFT;
         end
         ST_UNLOAD: begin
            w_misr_en = 1'b1;
            if (r_shift_cnt == SC_LAST) begin
               w_shift_cnt_nxt = '0;
               w_state_nxt     = ST_COMPARE;
            end else begin
               w_shift_cnt_nxt = r_shift_cnt + SCW'(1);
            end
         end
         ST_COMPARE: begin
            w_pass_nxt  = (w_sig == GOLDEN_SIG);
            w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (!start) begin
               w_pass_nxt  = 1'b0;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      // cancel wins; the partial signature is frozen for inspection
      if (abort && (r_state != ST_IDLE)) begin
         w_state_nxt     = ST_IDLE;
         w_shift_cnt_nxt = '0;
         w_pass_nxt      = 1'b0;
         w_misr_en       = 1'b0;
         w_misr_clr      = 1'b0;
      end
   end

   misr #(
      .SIG_WIDTH (SIG_WIDTH),
      .POLY      (POLY)
   ) u_misr (
      .clock     (clock),
      .reset     (reset),
      .clear     (w_misr_clr),
      .enable    (w_misr_en),
      .scan_out  (scan_out),
      .signature (w_sig)
   );

   assign lfsr_mode   = (r_state == ST_SHIFT);
   assign lfsr_reset  = (r_state == ST_INIT);
   assign scan_enable = (r_state == ST_SHIFT) || (r_state == ST_UNLOAD);
   assign busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
   assign done        = (r_state == ST_DONE);
   assign pass        = r_pass;
   assign signature   = w_sig;

endmodule

// File: tb/tb_bist_scan_controller.sv
// Directed bench for bist_scan_controller: nominal, mismatch, abort,
// async reset, DONE hold and minimum-geometry runs.
module tb_bist_scan_controller;

   localparam int L     = 8;
   localparam int N     = 16;
   localparam int CMP_C = 1 + N * (L + 1) + L;
   localparam int DN_C  = CMP_C + 1;

   // scan_out stream as a function of the cycle index after E0
   function automatic logic sbit(input int c);
      logic [31:0] v;
      v = c;
      return v[0] ^ v[2] ^ v[3] ^ v[5];
   endfunction

   // cycle-indexed reference signature after processing cycles < upto
   function automatic logic [15:0] model_sig(input int cl, input int np,
                                             input int upto);
      logic [15:0] s;
      logic        en;
      int          k;
      s = '0;
      for (int c = 0; c < upto; c++) begin
         en = 1'b0;
         if (c >= 1 && c <= np * (cl + 1)) begin
            k  = (c - 1) % (cl + 1);
            en = (k < cl) && (((c - 1) / (cl + 1)) > 0);
         end else if (c > np * (cl + 1) && c <= np * (cl + 1) + cl) begin
            en = 1'b1;
         end
         if (en)
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000)
              ^ {15'b0, sbit(c)};
      end
      return s;
   endfunction

   localparam logic [15:0] GOLD = model_sig(L, N, CMP_C);

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        scan_out = 1'b0;
   logic        start_m = 1'b0;
   logic        scan_out_m = 1'b0;

   logic        lm_a, lr_a, se_a, busy_a, done_a, pass_a;
   logic [15:0] sig_a;
   logic        lm_b, lr_b, se_b, busy_b, done_b, pass_b;
   logic [15:0] sig_b;
   logic        lm_m, lr_m, se_m, busy_m, done_m, pass_m;
   logic [15:0] sig_m;

   int n_cmp = 0;
   int n_bad = 0;

   int   o_done_a, o_done_b, o_lrst, o_cap, o_busy;
   logic prev_se, prev_lm;

   always #5 clock = ~clock;

   bist_scan_controller #(
      .CHAIN_LEN(L), .NUM_PATTERNS(N), .SIG_WIDTH(16), .GOLDEN_SIG(GOLD)
   ) dut_a (
      .clock(clock), .reset(reset), .start(start), .abort(abort),
      .scan_out(scan_out), .lfsr_mode(lm_a), .lfsr_reset(lr_a),
      .scan_enable(se_a), .busy(busy_a), .done(done_a), .pass(pass_a),
      .signature(sig_a)
   );

   bist_scan_controller #(
      .CHAIN_LEN(L), .NUM_PATTERNS(N), .SIG_WIDTH(16),
      .GOLDEN_SIG(GOLD ^ 16'h0001)
   ) dut_b (
      .clock(clock), .reset(reset), .start(start), .abort(abort),
      .scan_out(scan_out), .lfsr_mode(lm_b), .lfsr_reset(lr_b),
      .scan_enable(se_b), .busy(busy_b), .done(done_b), .pass(pass_b),
      .signature(sig_b)
   );

   bist_scan_controller #(
      .CHAIN_LEN(1), .NUM_PATTERNS(1), .SIG_WIDTH(16),
      .GOLDEN_SIG(16'h0001)
   ) dut_m (
      .clock(clock), .reset(reset), .start(start_m), .abort(abort),
      .scan_out(scan_out_m), .lfsr_mode(lm_m), .lfsr_reset(lr_m),
      .scan_enable(se_m), .busy(busy_m), .done(done_m), .pass(pass_m),
      .signature(sig_m)
   );

   // start a run on dut_a/dut_b and observe cycles 0..last_c after E0
   task automatic run(input bit hold, input int abort_at, input int last_c);
      o_done_a = -1;
      o_done_b = -1;
      o_lrst   = 0;
      o_cap    = 0;
      o_busy   = 0;
      prev_se  = 1'b0;
      prev_lm  = 1'b0;
      @(negedge clock);
      start = 1'b1;
      abort = 1'b0;
      for (int c = 0; c <= last_c; c++) begin
         @(negedge clock);
         scan_out = sbit(c);
         if (!hold) start = 1'b0;
         abort = (c == abort_at);
         if (lr_a) o_lrst++;
         if (!se_a && prev_se && prev_lm) o_cap++;
         if (busy_a) o_busy++;
         if (done_a && o_done_a < 0) o_done_a = c;
         if (done_b && o_done_b < 0) o_done_b = c;
         prev_se = se_a;
         prev_lm = lm_a;
      end
      abort = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      n_cmp++;
      if ({lm_a, lr_a, se_a, busy_a, done_a, pass_a, sig_a} !== 22'd0) begin
         n_bad++;
         $display("FAIL reset_a: got %h want 0",
                  {lm_a, lr_a, se_a, busy_a, done_a, pass_a, sig_a});
      end
      n_cmp++;
      if ({lm_b, lr_b, se_b, busy_b, done_b, pass_b, sig_b} !== 22'd0) begin
         n_bad++;
         $display("FAIL reset_b: got %h want 0",
                  {lm_b, lr_b, se_b, busy_b, done_b, pass_b, sig_b});
      end
      n_cmp++;
      if ({lm_m, lr_m, se_m, busy_m, done_m, pass_m, sig_m} !== 22'd0) begin
         n_bad++;
         $display("FAIL reset_m: got %h want 0",
                  {lm_m, lr_m, se_m, busy_m, done_m, pass_m, sig_m});
      end
      reset = 1'b1;
      repeat (3) @(negedge clock);
      n_cmp++;
      if ({busy_a, done_a, lr_a} !== 3'b000) begin
         n_bad++;
         $display("FAIL idle_after_reset: got %b want 000",
                  {busy_a, done_a, lr_a});
      end
   endtask

   task automatic test_nominal();
      run(1'b0, -1, DN_C);
      n_cmp++;
      if (o_done_a !== DN_C) begin
         n_bad++;
         $display("FAIL nom_done_at: got %0d want %0d", o_done_a, DN_C);
      end
      n_cmp++;
      if (pass_a !== 1'b1) begin
         n_bad++;
         $display("FAIL nom_pass: got %b want 1", pass_a);
      end
      n_cmp++;
      if (sig_a !== GOLD) begin
         n_bad++;
         $display("FAIL nom_sig: got %h want %h", sig_a, GOLD);
      end
      n_cmp++;
      if (o_lrst !== 1) begin
         n_bad++;
         $display("FAIL nom_lfsr_reset: got %0d want 1", o_lrst);
      end
      n_cmp++;
      if (o_cap !== N) begin
         n_bad++;
         $display("FAIL nom_captures: got %0d want %0d", o_cap, N);
      end
      n_cmp++;
      if (o_busy !== DN_C) begin
         n_bad++;
         $display("FAIL nom_busy_cycles: got %0d want %0d", o_busy, DN_C);
      end
      @(negedge clock);
      n_cmp++;
      if ({done_a, pass_a} !== 2'b00) begin
         n_bad++;
         $display("FAIL nom_exit: got %b want 00", {done_a, pass_a});
      end
   endtask

   task automatic test_mismatch();
      run(1'b0, -1, DN_C);
      n_cmp++;
      if (o_done_b !== DN_C) begin
         n_bad++;
         $display("FAIL mis_done_at: got %0d want %0d", o_done_b, DN_C);
      end
      n_cmp++;
      if (pass_b !== 1'b0) begin
         n_bad++;
         $display("FAIL mis_pass: got %b want 0", pass_b);
      end
      n_cmp++;
      if (sig_b !== GOLD) begin
         n_bad++;
         $display("FAIL mis_sig: got %h want %h", sig_b, GOLD);
      end
   endtask

   task automatic test_abort();
      // abort sampled at the end of cycle 48, a pattern 5 shift cycle
      run(1'b0, 48, 49);
      n_cmp++;
      if ({busy_a, done_a, lm_a, se_a, pass_a} !== 5'b00000) begin
         n_bad++;
         $display("FAIL abort_outputs: got %b want 00000",
                  {busy_a, done_a, lm_a, se_a, pass_a});
      end
      repeat (3) @(negedge clock);
      n_cmp++;
      if (sig_a !== model_sig(L, N, 48)) begin
         n_bad++;
         $display("FAIL abort_sig_hold: got %h want %h",
                  sig_a, model_sig(L, N, 48));
      end
      run(1'b0, -1, DN_C);
      n_cmp++;
      if ({o_done_a == DN_C, pass_a} !== 2'b11) begin
         n_bad++;
         $display("FAIL abort_rerun: done_at %0d pass %b want %0d 1",
                  o_done_a, pass_a, DN_C);
      end
   endtask

   task automatic test_done_hold();
      run(1'b1, -1, DN_C);
      n_cmp++;
      if (o_done_a !== DN_C) begin
         n_bad++;
         $display("FAIL hold_done_at: got %0d want %0d", o_done_a, DN_C);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         n_cmp++;
         if ({done_a, pass_a, busy_a} !== 3'b110) begin
            n_bad++;
            $display("FAIL hold_cycle_%0d: got %b want 110",
                     i, {done_a, pass_a, busy_a});
         end
      end
      start = 1'b0;
      @(negedge clock);
      n_cmp++;
      if ({done_a, pass_a, busy_a} !== 3'b000) begin
         n_bad++;
         $display("FAIL hold_release: got %b want 000",
                  {done_a, pass_a, busy_a});
      end
   endtask

   task automatic test_async_reset();
      run(1'b0, -1, 147);
      n_cmp++;
      if ({se_a, lm_a, busy_a} !== 3'b101) begin
         n_bad++;
         $display("FAIL ar_in_unload: got %b want 101", {se_a, lm_a, busy_a});
      end
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if ({lm_a, lr_a, se_a, busy_a, done_a, pass_a, sig_a} !== 22'd0) begin
         n_bad++;
         $display("FAIL ar_outputs: got %h want 0",
                  {lm_a, lr_a, se_a, busy_a, done_a, pass_a, sig_a});
      end
      @(negedge clock);
      reset = 1'b1;
      repeat (5) @(negedge clock);
      n_cmp++;
      if ({lr_a, lm_a, busy_a, done_a, sig_a} !== 20'd0) begin
         n_bad++;
         $display("FAIL ar_stay_idle: got %h want 0",
                  {lr_a, lm_a, busy_a, done_a, sig_a});
      end
   endtask

   task automatic test_min_config();
      int dat;
      dat = -1;
      @(negedge clock);
      start_m = 1'b1;
      for (int c = 0; c <= 5; c++) begin
         @(negedge clock);
         scan_out_m = sbit(c);
         start_m    = 1'b0;
         if (c == 2) begin
            n_cmp++;
            if (sig_m !== 16'h0000) begin
               n_bad++;
               $display("FAIL min_no_pat0: got %h want 0000", sig_m);
            end
         end
         if (done_m && dat < 0) dat = c;
      end
      n_cmp++;
      if (dat !== 5) begin
         n_bad++;
         $display("FAIL min_done_at: got %0d want 5", dat);
      end
      n_cmp++;
      if (sig_m !== 16'h0001) begin
         n_bad++;
         $display("FAIL min_sig: got %h want 0001", sig_m);
      end
      n_cmp++;
      if (pass_m !== 1'b1) begin
         n_bad++;
         $display("FAIL min_pass: got %b want 1", pass_m);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_mismatch();
      test_abort();
      test_done_hold();
      test_async_reset();
      test_min_config();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
